remote_comm: RTL and testbench
==============================

# remote_comm

Host-side command transmitter for the Knight's Tour robot. It accepts a 16-bit command and serializes it over a UART link to the robot as two bytes, high byte first. It also receives the robot's one-byte response, such as the positive acknowledge 8'hA5. In the system bench it stands in for the Bluetooth/phone remote, with its TX wired to the robot's RX and vice versa.

## Interface
- BAUD_DIV, 2604 — clocks per bit (19200 baud at 50 MHz); legal range 16..4095.
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- RX  in  1  serial input from the robot; idle high; asynchronous to clk.
- TX  out  1  serial output to the robot; idle high.
- cmd  in  16  command word; sampled only on the accepted snd_cmd cycle.
- snd_cmd  in  1  single-cycle request to transmit cmd.
- cmd_snt  out  1  level; high once both bytes of the last command have completed.
- resp_rdy  out  1  level; high while resp holds a newly received byte.
- resp  out  8  last received byte.

## Operation
- UART framing is 8N1, LSB first: start bit 0, eight data bits, stop bit 1, each bit BAUD_DIV clocks long.
- Transmit sequencer states:
  - IDLE: on snd_cmd, latch cmd[7:0], start a frame carrying cmd[15:8], clear cmd_snt, go to HIGH.
  - HIGH: when that frame's stop bit ends, start the cmd[7:0] frame and go to LOW.
  - LOW: when that frame's stop bit ends, set cmd_snt and go to IDLE.
- snd_cmd is ignored in HIGH and LOW; cmd_snt and the latched low byte are unchanged by it.
- Receiver:
  - RX is double-flop synchronized; both flops preset to 1.
  - A falling edge while the receiver is idle starts a frame.
  - Bits are sampled at BAUD_DIV/2 after the edge, then every BAUD_DIV clocks.
  - After the 8th data bit is sampled and the stop bit sample is taken, the byte is loaded into resp and resp_rdy is set.
  - The stop-bit value is not checked.
  - If the start bit samples as 1 at mid-bit, the frame is aborted with no resp_rdy.
- resp_rdy is cleared on an accepted snd_cmd or at the start of the next received frame, whichever comes first. If both occur in the same cycle, the result is still cleared.
- Reset values: TX=1, cmd_snt=0, resp_rdy=0, resp=8'h00, sequencer state IDLE, receiver idle.
- Asserting rst_n low mid-frame aborts immediately. TX returns to 1 asynchronously and no partial byte is reported.

## Timing
- snd_cmd sampled high at edge N means TX drives the start bit from edge N+1.
- Gap between the end of the high-byte stop bit and the low-byte start bit: at most 2 clocks.
- cmd_snt rises within 2 clocks of the end of the low-byte stop bit. The total from snd_cmd to cmd_snt is 20×BAUD_DIV + ≤4 clocks.
- Receive latency: resp_rdy rises within 3 clocks after the stop-bit sample point, which is 9.5×BAUD_DIV after the RX falling edge.
- The bit counter and baud counter are sized for BAUD_DIV up to 4095; counters do not wrap during a frame.

## Configuration
- REMOTE_COMM_ACK_CHK_EN defined: adds output pos_ack (1 bit).
  - pos_ack is registered and rises together with resp_rdy when the received byte equals 8'hA5.
  - It is cleared with resp_rdy.
  - Reset value is 0.
- REMOTE_COMM_ACK_CHK_EN not defined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Package remote_comm_pkg holds:
  - the BAUD_DIV default (2604);
  - POS_ACK = 8'hA5;
  - the sequencer state enum {IDLE, HIGH, LOW};
  - the UART tx/rx state enums.
- One sub-module, uart_trx, contains the full-duplex UART.
  - Transmit side: trmt/tx_data in, tx_done out.
  - Receive side: rx_rdy/rx_data out, clr_rdy in.
- remote_comm contains only the byte sequencer, the cmd_snt flag, and the optional ack compare.

## Test plan
Run with BAUD_DIV=16, unless a scenario states otherwise.
- Reset: hold rst_n low, then release → TX=1, cmd_snt=0, resp_rdy=0, resp=0 for 100 clocks with no activity.
- Send: pulse snd_cmd with cmd=16'h2F04 → decoded TX frames are 8'h2F then 8'h04. cmd_snt rises 320–324 clocks after snd_cmd and stays high.
- Receive: drive an RX frame of 8'hA5 → resp=8'hA5 and resp_rdy=1 around 152 clocks after the start edge. With the macro defined, pos_ack=1 as well. A frame of 8'h5A gives resp=8'h5A with pos_ack=0.
- Busy: pulse snd_cmd with 16'h1234, then pulse snd_cmd with 16'hFFFF 50 clocks later → only bytes 12, 34 are transmitted, and cmd_snt rises once.
- Glitch: pull RX low for 4 clocks → no resp_rdy, and the receiver re-arms for the next frame.
- Reset mid-frame: assert rst_n during the high byte → TX=1 immediately, cmd_snt=0. A fresh snd_cmd with 16'hA55A afterwards transmits correctly.

Source files
------------

// File: rtl/remote_comm_pkg.sv
// Shared constants and state encodings for the remote_comm command transmitter and its UART.
// No logic, so no latency; backpressure is not applicable.
package remote_comm_pkg;

  localparam int         BAUD_DIV_DEF = 2604;
  localparam logic [7:0] POS_ACK      = 8'hA5;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} seq_state_t;
  typedef enum logic       {TX_IDLE, TX_BUSY} tx_state_t;
  typedef enum logic       {RX_IDLE, RX_BUSY} rx_state_t;

endpackage

// File: rtl/uart_trx.sv
// Full-duplex 8N1 UART. TX: a frame starts the edge after trmt and tx_done pulses when the stop bit ends.
// RX: rx_rdy is set about 9.5 bit times after the start edge. There is no backpressure: trmt is only issued while idle.
module uart_trx
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       tx,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       rx_rdy,
  output logic [7:0] rx_data,
  input  logic       clr_rdy
);

  localparam logic [11:0] BIT_LAST  = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF_LAST = 12'(BAUD_DIV / 2 - 1);

  tx_state_t   tx_state;
  logic [9:0]  tx_shft;
  logic [11:0] tx_baud;
  logic [3:0]  tx_bits;

  rx_state_t   rx_state;
  logic        rx_ff1, rx_ff2, rx_prev;
  logic [11:0] rx_cnt;
  logic [3:0]  rx_bits;
  logic [7:0]  rx_shft;

  // Shifter resets to all ones so the line idles high straight out of reset.
  assign tx = tx_shft[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_shft  <= '1;
      tx_baud  <= '0;
      tx_bits  <= '0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (tx_state)
        TX_IDLE: if (trmt) begin
          tx_shft  <= {1'b1, tx_data, 1'b0};
          tx_baud  <= '0;
          tx_bits  <= '0;
          tx_state <= TX_BUSY;
        end
        TX_BUSY: if (tx_baud == BIT_LAST) begin
          tx_baud <= '0;
          tx_shft <= {1'b1, tx_shft[9:1]};
          tx_bits <= tx_bits + 4'd1;
          if (tx_bits == 4'd9) begin
            tx_state <= TX_IDLE;
            tx_done  <= 1'b1;
          end
        end else begin
          tx_baud <= tx_baud + 12'd1;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1  <= 1'b1;
      rx_ff2  <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_ff1  <= rx;
      rx_ff2  <= rx_ff1;
      rx_prev <= rx_ff2;
    end
  end

  // rx_bits counts samples: 0 is the start bit, 1..8 are data, 9 is the stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shft  <= '0;
      rx_data  <= '0;
      rx_rdy   <= 1'b0;
    end else begin
      if (clr_rdy) rx_rdy <= 1'b0;
      case (rx_state)
        RX_IDLE: if (rx_prev && !rx_ff2) begin
          rx_state <= RX_BUSY;
          rx_cnt   <= HALF_LAST;
          rx_bits  <= '0;
          rx_rdy   <= 1'b0;
        end
        RX_BUSY: if (rx_cnt != 12'd0) begin
          rx_cnt <= rx_cnt - 12'd1;
        end else begin
          rx_cnt  <= BIT_LAST;
          rx_bits <= rx_bits + 4'd1;
          if (rx_bits == 4'd0) begin
            if (rx_ff2) rx_state <= RX_IDLE;
          end else if (rx_bits == 4'd9) begin
            rx_state <= RX_IDLE;
            rx_data  <= rx_shft;
            rx_rdy   <= 1'b1;
          end else begin
            rx_shft <= {rx_ff2, rx_shft[7:1]};
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/remote_comm.sv
// Sends a 16-bit command as two UART bytes, high byte first, and captures one-byte responses. The optional pos_ack output is enabled by REMOTE_COMM_ACK_CHK_EN.
// Latency: 20*BAUD_DIV+4 clocks from snd_cmd to cmd_snt. Backpressure: snd_cmd is dropped while a command is in flight.
module remote_comm
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        cmd_snt,
  output logic        resp_rdy,
  output logic [7:0]  resp
`ifdef REMOTE_COMM_ACK_CHK_EN
  ,
  output logic        pos_ack
`endif
);

  seq_state_t state;
  logic [7:0] low_byte, tx_byte;
  logic       trmt, tx_done, accept;

  assign accept = (state == IDLE) && snd_cmd;

  uart_trx #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (RX),
    .tx      (TX),
    .trmt    (trmt),
    .tx_data (tx_byte),
    .tx_done (tx_done),
    .rx_rdy  (resp_rdy),
    .rx_data (resp),
    .clr_rdy (accept)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      low_byte <= '0;
      tx_byte  <= '0;
      trmt     <= 1'b0;
      cmd_snt  <= 1'b0;
    end else begin
      trmt <= 1'b0;
      case (state)
        IDLE: if (snd_cmd) begin
          low_byte <= cmd[7:0];
          tx_byte  <= cmd[15:8];
          trmt     <= 1'b1;
          cmd_snt  <= 1'b0;
          state    <= HIGH;
        end
        HIGH: if (tx_done) begin
          tx_byte <= low_byte;
          trmt    <= 1'b1;
          state   <= LOW;
        end
        LOW: if (tx_done) begin
          cmd_snt <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef REMOTE_COMM_ACK_CHK_EN
  // Both operands are flop outputs, so pos_ack rises and falls with resp_rdy.
  assign pos_ack = resp_rdy && (resp == POS_ACK);
`endif

endmodule

// File: tb/tb_remote_comm.sv
// Directed bench for remote_comm at BAUD_DIV=16: reset, send, receive, busy, glitch and mid-frame reset.
module tb_remote_comm;

  logic        clk = 1'b0;
  logic        rst_n, RX, snd_cmd;
  logic [15:0] cmd;
  logic        TX, cmd_snt, resp_rdy;
  logic [7:0]  resp;
  logic        pos_ack;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_snd = 0;
  int snt_rises = 0;
  logic snt_prev = 1'b0;

  remote_comm #(.BAUD_DIV(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .RX       (RX),
    .TX       (TX),
    .cmd      (cmd),
    .snd_cmd  (snd_cmd),
    .cmd_snt  (cmd_snt),
    .resp_rdy (resp_rdy),
    .resp     (resp)
`ifdef REMOTE_COMM_ACK_CHK_EN
    ,
    .pos_ack  (pos_ack)
`endif
  );

`ifndef REMOTE_COMM_ACK_CHK_EN
  assign pos_ack = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (cmd_snt === 1'b1 && snt_prev === 1'b0) snt_rises <= snt_rises + 1;
    snt_prev <= cmd_snt;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // snd_cmd is sampled by edge N; t_snd holds N on return (one half-clock after N).
  task automatic pulse_cmd(input logic [15:0] v);
    @(negedge clk);
    cmd = v;
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    t_snd = cyc;
  endtask

  task automatic get_tx(output logic [7:0] b, output logic ok);
    int n;
    n = 0;
    ok = 1'b1;
    b = 8'h00;
    while (TX !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (TX !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    repeat (8) @(negedge clk);
    if (TX !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(negedge clk);
      b[i] = TX;
    end
    repeat (16) @(negedge clk);
    if (TX !== 1'b1) ok = 1'b0;
  endtask

  task automatic drive_rx(input logic [7:0] b);
    RX = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (16) @(negedge clk);
    end
    RX = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic wait_snt(output int lat);
    int n;
    n = 0;
    while (cmd_snt !== 1'b1 && n < 800) begin
      @(negedge clk);
      n++;
    end
    lat = (cmd_snt === 1'b1) ? (cyc - t_snd) : -1;
  endtask

  task automatic wait_rdy(input int t0, output int lat);
    int n;
    n = 0;
    while (resp_rdy !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    lat = (resp_rdy === 1'b1) ? (cyc - t0) : -1;
  endtask

  initial begin
    logic [7:0] b1, b2;
    logic ok1, ok2, quiet;
    int lat, t0, rises0;

    rst_n = 1'b0;
    RX = 1'b1;
    snd_cmd = 1'b0;
    cmd = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_tx", TX, 1);
    check("rst_cmd_snt", cmd_snt, 0);
    check("rst_resp_rdy", resp_rdy, 0);
    check("rst_resp", resp, 8'h00);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (TX !== 1'b1 || cmd_snt !== 1'b0 || resp_rdy !== 1'b0 || resp !== 8'h00) quiet = 1'b0;
    end
    check("idle_quiet", quiet, 1);

    // Send 2F04: TX starts the edge after the sampling edge; cmd_snt arrives 324 clocks after it.
    pulse_cmd(16'h2F04);
    check("start_not_yet", TX, 1);
    @(negedge clk);
    check("start_bit_n1", TX, 0);
    get_tx(b1, ok1);
    get_tx(b2, ok2);
    check("send_hi_frame", ok1, 1);
    check("send_hi_byte", b1, 8'h2F);
    check("send_lo_frame", ok2, 1);
    check("send_lo_byte", b2, 8'h04);
    wait_snt(lat);
    check("send_snt_lat", (lat >= 320 && lat <= 324), 1);
    repeat (20) @(negedge clk);
    check("send_snt_hold", cmd_snt, 1);

    // Receive A5: resp_rdy about 152 clocks after the start edge plus synchronizer delay.
    @(negedge clk);
    t0 = cyc;
    fork
      drive_rx(8'hA5);
      wait_rdy(t0, lat);
    join
    check("rx_a5_lat", (lat >= 150 && lat <= 158), 1);
    check("rx_a5_resp", resp, 8'hA5);
    check("rx_a5_rdy", resp_rdy, 1);
`ifdef REMOTE_COMM_ACK_CHK_EN
    check("rx_a5_ack", pos_ack, 1);
`endif

    fork
      drive_rx(8'h5A);
      begin
        repeat (10) @(negedge clk);
        check("rx_rdy_clr_on_start", resp_rdy, 0);
      end
    join
    check("rx_5a_resp", resp, 8'h5A);
    check("rx_5a_rdy", resp_rdy, 1);
`ifdef REMOTE_COMM_ACK_CHK_EN
    check("rx_5a_ack", pos_ack, 0);
`endif

    // Glitch: 4-clock low pulse aborts at the start-bit sample.
    RX = 1'b0;
    repeat (4) @(negedge clk);
    RX = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_rdy", resp_rdy, 0);
    check("glitch_resp", resp, 8'h5A);
    drive_rx(8'h3C);
    check("rearm_resp", resp, 8'h3C);
    check("rearm_rdy", resp_rdy, 1);

    // Busy: second snd_cmd 50 clocks in must be dropped.
    rises0 = snt_rises;
    pulse_cmd(16'h1234);
    check("busy_rdy_clr", resp_rdy, 0);
    check("busy_snt_clr", cmd_snt, 0);
    fork
      begin
        get_tx(b1, ok1);
        get_tx(b2, ok2);
      end
      begin
        repeat (48) @(negedge clk);
        pulse_cmd(16'hFFFF);
      end
    join
    check("busy_hi_byte", {ok1, b1}, {1'b1, 8'h12});
    check("busy_lo_byte", {ok2, b2}, {1'b1, 8'h34});
    wait_snt(lat);
    check("busy_snt_seen", (lat > 0), 1);
    quiet = 1'b1;
    repeat (400) begin
      @(negedge clk);
      if (TX !== 1'b1) quiet = 1'b0;
    end
    check("busy_tail_quiet", quiet, 1);
    check("busy_snt_once", snt_rises - rises0, 1);

    // Reset during the high byte (data bit 1 of 8'h80 is low).
    pulse_cmd(16'h8001);
    repeat (40) @(negedge clk);
    check("mid_tx_low", TX, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", TX, 1);
    check("mid_rst_snt", cmd_snt, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_tx_idle", TX, 1);
    pulse_cmd(16'hA55A);
    get_tx(b1, ok1);
    get_tx(b2, ok2);
    check("post_rst_hi", {ok1, b1}, {1'b1, 8'hA5});
    check("post_rst_lo", {ok2, b2}, {1'b1, 8'h5A});
    wait_snt(lat);
    check("post_rst_snt_lat", (lat >= 320 && lat <= 324), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
